// File: rtl/assert_log_pkg.sv
// ---------------------------------------------------------------------------
// assert_log_pkg
//   Shared types and helpers for the assertion event logger.
//   - SRC_W / LVL_W : source-index and FIFO-level widths for the default
//                     configuration (4 sources, 8-deep FIFO).
//   - fail_rec_t    : one failure record {source index, timestamp}.
//   - sat_add       : saturating add, clamps a + inc to max.
// ---------------------------------------------------------------------------
package assert_log_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int TS_W_DEF    = 32;
    localparam int DEPTH_DEF   = 8;

    localparam int SRC_W = $clog2(NUM_SRC_DEF);
    localparam int LVL_W = $clog2(DEPTH_DEF) + 1;

    typedef struct packed {
        logic [SRC_W-1:0]    src;
        logic [TS_W_DEF-1:0] ts;
    } fail_rec_t;

    // Sum is formed one bit wider than the operands so the carry is never
    // lost before the clamp; callers keep their counters well below 64 bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] inc,
                                            input logic [63:0] max);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return (sum > {1'b0, max}) ? max : sum[63:0];
    endfunction

endpackage

// File: rtl/assert_log_fifo.sv
// ---------------------------------------------------------------------------
// assert_log_fifo
//   Synchronous FIFO for failure records.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : synchronous flush (wins over push/pop)
//     push, wdata : write request; ignored when full unless pop frees a slot
//     pop         : remove head; ignored when empty
//     full, empty : status
//     level       : occupancy 0..DEPTH
//     head        : record at the head, all-zero while empty
// ---------------------------------------------------------------------------
module assert_log_fifo
    import assert_log_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type rec_t = fail_rec_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  rec_t                   wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output rec_t                   head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign head  = empty ? rec_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty && !clear;
        do_push  = push && (!full || do_pop) && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/assert_event_logger.sv
// ---------------------------------------------------------------------------
// assert_event_logger
//   Collects pass/fail pulses from NUM_SRC (>=2) assertion checkers, keeps
//   saturating totals, timestamps failures and queues one record per cycle.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     clear               : synchronous clear of all state, beats every event
//     pass_i, fail_i      : per-source one-cycle pulses
//     rd_valid/rd_ready   : head-of-FIFO handshake
//     rd_src, rd_ts       : head record
//     pass_cnt, fail_cnt  : saturating totals (fail wins over pass per source)
//     drop_cnt            : fails that did not produce a record
//     fifo_level          : FIFO occupancy
//     first_ts, any_fail  : timestamp / flag of first fail since reset/clear
// ---------------------------------------------------------------------------
module assert_event_logger
    import assert_log_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [NUM_SRC-1:0]         pass_i,
    input  logic [NUM_SRC-1:0]         fail_i,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(NUM_SRC)-1:0] rd_src,
    output logic [TS_W-1:0]            rd_ts,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [TS_W-1:0]            first_ts,
    output logic                       any_fail
);

    localparam int RSW = $clog2(NUM_SRC);
    localparam int PCW = RSW + 1;   // popcount width, holds 0..NUM_SRC
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [RSW-1:0]  src;
        logic [TS_W-1:0] ts;
    } rec_t;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [TS_W-1:0]  first_ts_q, first_ts_d;
    logic             any_fail_q, any_fail_d;

    logic [NUM_SRC-1:0] pass_eff;
    logic [PCW-1:0]     n_pass, n_fail, n_drop;
    logic [RSW-1:0]     src_sel;
    logic               fail_any;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    rec_t               fifo_wdata, fifo_head;

    // Head comes straight out of FIFO storage, so fail_i never reaches rd_*
    // combinationally.
    assert_log_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (fifo_head)
    );

    assign rd_valid = !fifo_empty;
    assign rd_src   = fifo_head.src;
    assign rd_ts    = fifo_head.ts;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign first_ts = first_ts_q;
    assign any_fail = any_fail_q;

    // Event decode: popcounts and lowest-index failing source.
    always_comb begin
        pass_eff = pass_i & ~fail_i;
        fail_any = |fail_i;
        n_pass   = '0;
        n_fail   = '0;
        src_sel  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            n_pass = n_pass + PCW'(pass_eff[k]);
            n_fail = n_fail + PCW'(fail_i[k]);
        end
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (fail_i[k]) src_sel = RSW'(k);
        end
    end

    // Record path: a pop in the same cycle frees the slot for the push.
    always_comb begin
        fifo_pop        = rd_valid && rd_ready;
        fifo_push       = !clear && fail_any && (!fifo_full || fifo_pop);
        fifo_wdata.src  = src_sel;
        fifo_wdata.ts   = ts_q;
        // Every failing source except the one that was written is a drop.
        n_drop          = n_fail - PCW'(fifo_push);
    end

    always_comb begin
        ts_d       = ts_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        drop_cnt_d = drop_cnt_q;
        first_ts_d = first_ts_q;
        any_fail_d = any_fail_q;
        if (clear) begin
            ts_d       = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            drop_cnt_d = '0;
            first_ts_d = '0;
            any_fail_d = 1'b0;
        end else begin
            ts_d       = ts_q + TS_W'(1);
            pass_cnt_d = CNT_W'(sat_add(64'(pass_cnt_q), 64'(n_pass), 64'(CNT_MAX)));
            fail_cnt_d = CNT_W'(sat_add(64'(fail_cnt_q), 64'(n_fail), 64'(CNT_MAX)));
            drop_cnt_d = CNT_W'(sat_add(64'(drop_cnt_q), 64'(n_drop), 64'(CNT_MAX)));
            // Captured on the first failing cycle even if its record is dropped.
            if (fail_any && !any_fail_q) begin
                any_fail_d = 1'b1;
                first_ts_d = ts_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            drop_cnt_q <= '0;
            first_ts_q <= '0;
            any_fail_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            first_ts_q <= first_ts_d;
            any_fail_q <= any_fail_d;
        end
    end

endmodule

// File: tb/tb_assert_event_logger.sv
// ---------------------------------------------------------------------------
// tb_assert_event_logger
//   Two loggers share one stimulus stream: the default 16-bit counter build
//   and a 4-bit counter build that saturates quickly. A queue-based model
//   tracks unbounded totals and the record list; saturation is a clamp.
// ---------------------------------------------------------------------------
module tb_assert_event_logger;

    localparam int DEPTH = 8;
    localparam longint MAX_B = 65535;
    localparam longint MAX_S = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        rd_ready = 1'b0;
    logic [3:0]  pass_i = '0;
    logic [3:0]  fail_i = '0;

    logic        rd_valid_b, any_fail_b, rd_valid_s, any_fail_s;
    logic [1:0]  rd_src_b, rd_src_s;
    logic [31:0] rd_ts_b, first_ts_b, rd_ts_s, first_ts_s;
    logic [15:0] pass_cnt_b, fail_cnt_b, drop_cnt_b;
    logic [3:0]  pass_cnt_s, fail_cnt_s, drop_cnt_s;
    logic [3:0]  fifo_level_b, fifo_level_s;

    assert_event_logger #(.NUM_SRC(4), .TS_W(32), .CNT_W(16), .DEPTH(DEPTH)) u_big (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pass_i(pass_i), .fail_i(fail_i),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_src(rd_src_b), .rd_ts(rd_ts_b),
        .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b), .drop_cnt(drop_cnt_b),
        .fifo_level(fifo_level_b), .first_ts(first_ts_b), .any_fail(any_fail_b)
    );

    assert_event_logger #(.NUM_SRC(4), .TS_W(32), .CNT_W(4), .DEPTH(DEPTH)) u_small (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pass_i(pass_i), .fail_i(fail_i),
        .rd_valid(rd_valid_s), .rd_ready(rd_ready), .rd_src(rd_src_s), .rd_ts(rd_ts_s),
        .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s), .drop_cnt(drop_cnt_s),
        .fifo_level(fifo_level_s), .first_ts(first_ts_s), .any_fail(any_fail_s)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  src;
        logic [31:0] ts;
    } mrec_t;

    mrec_t       m_q[$];
    longint      m_pass, m_fail, m_drop;
    logic [31:0] m_ts, m_first;
    bit          m_any;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_drop = 0;
        m_ts = '0; m_first = '0; m_any = 1'b0;
    endtask

    // Applies one clock edge worth of the logging rules to the model.
    task automatic model_step();
        int    nf, np;
        mrec_t r;
        if (!rst_n) return;
        if (clear) begin
            model_reset();
            return;
        end
        nf = $countones(fail_i);
        np = $countones(pass_i & ~fail_i);
        m_pass += np;
        m_fail += nf;
        if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
        if (nf > 0) begin
            if (!m_any) begin
                m_any   = 1'b1;
                m_first = m_ts;
            end
            r.src = 2'd0;
            for (int k = 3; k >= 0; k--) if (fail_i[k]) r.src = 2'(k);
            r.ts = m_ts;
            if (m_q.size() < DEPTH) begin
                m_q.push_back(r);
                m_drop += nf - 1;
            end else begin
                m_drop += nf;
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both builds against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", 64'(rd_valid_b), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("rd_src", 64'(rd_src_b), 64'(m_q[0].src));
                chk("rd_ts",  64'(rd_ts_b),  64'(m_q[0].ts));
            end else begin
                chk("rd_src_idle", 64'(rd_src_b), 64'd0);
                chk("rd_ts_idle",  64'(rd_ts_b),  64'd0);
            end
            chk("pass_cnt",   64'(pass_cnt_b),   64'(sat(m_pass, MAX_B)));
            chk("fail_cnt",   64'(fail_cnt_b),   64'(sat(m_fail, MAX_B)));
            chk("drop_cnt",   64'(drop_cnt_b),   64'(sat(m_drop, MAX_B)));
            chk("fifo_level", 64'(fifo_level_b), 64'(m_q.size()));
            chk("first_ts",   64'(first_ts_b),   64'(m_first));
            chk("any_fail",   64'(any_fail_b),   64'(m_any));
            chk("s_pass_cnt", 64'(pass_cnt_s),   64'(sat(m_pass, MAX_S)));
            chk("s_fail_cnt", 64'(fail_cnt_s),   64'(sat(m_fail, MAX_S)));
            chk("s_drop_cnt", 64'(drop_cnt_s),   64'(sat(m_drop, MAX_S)));
            chk("s_level",    64'(fifo_level_s), 64'(m_q.size()));
            chk("s_rd_valid", 64'(rd_valid_s),   64'(m_q.size() != 0));
            chk("s_first_ts", 64'(first_ts_s),   64'(m_first));
            chk("s_any_fail", 64'(any_fail_s),   64'(m_any));
            if (m_q.size() != 0) chk("s_rd_ts", 64'(rd_ts_s), 64'(m_q[0].ts));
        end
    end

    // Drive inputs, take one clock, step the model; returns at posedge+3.
    task automatic cyc(input logic [3:0] p, input logic [3:0] f,
                       input logic rdy, input logic clr);
        pass_i   = p;
        fail_i   = f;
        rd_ready = rdy;
        clear    = clr;
        @(posedge clk);
        model_step();
        #3;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) cyc(4'd0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int          rdy_bias;
        logic [3:0]  p, f;
        int          r;

        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_rd_valid", 64'(rd_valid_b), 64'd0);
        chk("reset_level",    64'(fifo_level_b), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Reset mid-run after three logged fails
        cyc(4'd0, 4'b0001, 1'b0, 1'b0);
        cyc(4'd0, 4'b0010, 1'b0, 1'b0);
        cyc(4'd0, 4'b0100, 1'b0, 1'b0);
        chk("t1_level3", 64'(fifo_level_b), 64'd3);
        chk("t1_fail3",  64'(fail_cnt_b),   64'd3);
        rst_n = 1'b0;
        model_reset();
        repeat (2) cyc(4'd0, 4'd0, 1'b0, 1'b0);
        chk("t1_fail0",   64'(fail_cnt_b), 64'd0);
        chk("t1_valid0",  64'(rd_valid_b), 64'd0);
        chk("t1_any0",    64'(any_fail_b), 64'd0);
        chk("t1_level0",  64'(fifo_level_b), 64'd0);
        rst_n = 1'b1;

        // Single fail at ts=10 (ts restarted from 0 after reset)
        repeat (10) cyc(4'd0, 4'd0, 1'b1, 1'b0);
        cyc(4'd0, 4'b0100, 1'b1, 1'b0);
        chk("t2_valid",  64'(rd_valid_b), 64'd1);
        chk("t2_src",    64'(rd_src_b),   64'd2);
        chk("t2_ts",     64'(rd_ts_b),    64'd10);
        chk("t2_fail",   64'(fail_cnt_b), 64'd1);
        chk("t2_first",  64'(first_ts_b), 64'd10);

        // Simultaneous fails, pass on a failing source is ignored
        cyc(4'd0, 4'd0, 1'b1, 1'b0);
        cyc(4'b0001, 4'b1011, 1'b1, 1'b0);
        chk("t3_fail",  64'(fail_cnt_b),   64'd4);
        chk("t3_drop",  64'(drop_cnt_b),   64'd2);
        chk("t3_pass",  64'(pass_cnt_b),   64'd0);
        chk("t3_src",   64'(rd_src_b),     64'd0);
        chk("t3_level", 64'(fifo_level_b), 64'd1);

        // Clear beats a same-cycle fail; ts restarts at 0
        cyc(4'd0, 4'b0001, 1'b0, 1'b1);
        chk("t6_fail0",  64'(fail_cnt_b),   64'd0);
        chk("t6_level0", 64'(fifo_level_b), 64'd0);
        chk("t6_any0",   64'(any_fail_b),   64'd0);
        chk("t6_drop0",  64'(drop_cnt_b),   64'd0);
        cyc(4'd0, 4'b0010, 1'b0, 1'b0);
        chk("t6_ts0",    64'(rd_ts_b),      64'd0);
        chk("t6_src1",   64'(rd_src_b),     64'd1);
        chk("t6_any1",   64'(any_fail_b),   64'd1);

        // Fill under backpressure, then a fail alongside a pop
        cyc(4'd0, 4'd0, 1'b0, 1'b1);
        repeat (10) cyc(4'd0, 4'b0100, 1'b0, 1'b0);
        chk("t4_level8", 64'(fifo_level_b), 64'd8);
        chk("t4_drop2",  64'(drop_cnt_b),   64'd2);
        chk("t4_head",   64'(rd_ts_b),      64'd0);
        cyc(4'd0, 4'b1000, 1'b1, 1'b0);
        chk("t4_level_hold", 64'(fifo_level_b), 64'd8);
        chk("t4_no_drop",    64'(drop_cnt_b),   64'd2);
        chk("t4_next_head",  64'(rd_ts_b),      64'd1);
        chk("t4_fail11",     64'(fail_cnt_b),   64'd11);

        // Saturation of the 4-bit build
        cyc(4'd0, 4'd0, 1'b1, 1'b1);
        repeat (20) cyc(4'b0001, 4'd0, 1'b1, 1'b0);
        chk("t5_sat15", 64'(pass_cnt_s), 64'd15);
        chk("t5_big20", 64'(pass_cnt_b), 64'd20);
        repeat (3) cyc(4'b1111, 4'd0, 1'b1, 1'b0);
        chk("t5_hold15", 64'(pass_cnt_s), 64'd15);
        chk("t5_big32",  64'(pass_cnt_b), 64'd32);

        // Randomized traffic with varying consumer throughput
        rdy_bias = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % 300 == 0) rdy_bias = $urandom_range(0, 4);
            r = $urandom_range(0, 999);
            if (r < 3) begin
                pass_i = '0; fail_i = '0; clear = 1'b0;
                do_reset($urandom_range(1, 2));
            end else begin
                p = 4'($urandom);
                f = 4'($urandom & $urandom & $urandom);
                cyc(p, f, 1'($urandom_range(0, 3) < rdy_bias), 1'(r < 8));
            end
        end

        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
